epg: RTL and testbench

- Ethernet packet generator: the transmit-side counterpart of the epd detector.
- Serialises one frame per start request onto the same byte/control interface epd consumes: 7x 0x55 preamble, 0xD5 SFD, DST, SRC, type/length, streamed payload with zero pad, then CRC-32 FCS.
- Between frames it drives a minimum inter-frame gap (control=0, data=0x00).
- Used as the stimulus source in front of epd and as the TX path of the design.

---
 rtl/epd_pkg.sv | 21 ++
 rtl/crc32_d8.sv | 19 +
 rtl/epg.sv | 125 ++++++++++++
 tb/tb_epg.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/epd_pkg.sv
// epd_pkg: framing constants, CRC-32 parameters and FSM encoding shared by epd and epg
package epd_pkg;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam int PREAMBLE_LEN = 7;
  localparam int ADDR_LEN = 6;
  localparam int TL_LEN = 2;
  localparam int FCS_LEN = 4;
  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  typedef enum logic [3:0] {
    ST_IDLE, ST_PRE, ST_SFD, ST_DST, ST_SRC, ST_TL, ST_PAY, ST_PAD, ST_FCS, ST_IFG
  } state_t;
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ (CRC32_POLY & {32{r[0] ^ d[i]}});
    return r;
  endfunction
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: byte-wide reflected CRC-32 next-state function with clear/enable register
module crc32_d8
  import epd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc,
  output logic [31:0] crc_next
);
  assign crc_next = crc32_byte(crc, d);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc <= CRC32_INIT;
    else if (clr) crc <= CRC32_INIT;
    else if (en) crc <= crc_next;
  end
endmodule

// File: rtl/epg.sv
// epg: Ethernet frame serialiser with preamble, zero pad, CRC-32 FCS and inter-frame gap
module epg
  import epd_pkg::*;
#(
  parameter int IFG_MIN = 12,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] dst_addr,
  input  logic [47:0] src_addr,
  input  logic [15:0] type_length,
  input  logic [7:0]  payload_data,
  input  logic        payload_valid,
  input  logic        payload_last,
  output logic        payload_ready,
  output logic [7:0]  data,
  output logic        control,
  output logic        busy,
  output logic        frame_done,
  output logic        tx_error,
  output logic [3:0]  tx_packet_counter
);
  localparam logic [10:0] MIN_L = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_L = 11'(MAX_PAYLOAD);
  localparam logic [10:0] IFG_L = 11'(IFG_MIN - 1);
  state_t state, state_n;
  logic [10:0] idx, idx_n;
  logic [47:0] dst_q, src_q;
  logic [15:0] tl_q;
  logic pay_done, pay_done_n, control_n, err_n, done_n, take;
  logic [7:0] data_n;
  logic [31:0] crc, crc_next, fcs;
  logic [2:0] i_n;
  crc32_d8 u_crc (
    .clk(clock),
    .rst(reset),
    .clr(state == ST_SFD),
    .en(state inside {ST_DST, ST_SRC, ST_TL, ST_PAY, ST_PAD}),
    .d(data),
    .crc(crc),
    .crc_next(crc_next)
  );
  assign busy = state != ST_IDLE;
  assign payload_ready = (state == ST_TL && idx == 11'(TL_LEN - 1)) || (state == ST_PAY && !pay_done);
  assign take = payload_ready && payload_valid;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      idx <= '0;
      pay_done <= 1'b0;
      data <= '0;
      control <= 1'b0;
      tx_error <= 1'b0;
      frame_done <= 1'b0;
      tx_packet_counter <= '0;
      dst_q <= '0;
      src_q <= '0;
      tl_q <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      pay_done <= pay_done_n;
      data <= data_n;
      control <= control_n;
      tx_error <= err_n;
      frame_done <= done_n;
      tx_packet_counter <= tx_packet_counter + {3'b0, done_n};
      if (state == ST_IDLE && start) begin
        dst_q <= dst_addr;
        src_q <= src_addr;
        tl_q <= type_length;
      end
    end
  end
  always_comb begin
    state_n = state;
    idx_n = idx + 11'd1;
    pay_done_n = pay_done;
    case (state)
      ST_IDLE: begin
        idx_n = '0;
        pay_done_n = 1'b0;
        state_n = start ? ST_PRE : ST_IDLE;
      end
      ST_PRE: if (idx == 11'(PREAMBLE_LEN - 1)) begin state_n = ST_SFD; idx_n = '0; end
      ST_SFD: begin state_n = ST_DST; idx_n = '0; end
      ST_DST: if (idx == 11'(ADDR_LEN - 1)) begin state_n = ST_SRC; idx_n = '0; end
      ST_SRC: if (idx == 11'(ADDR_LEN - 1)) begin state_n = ST_TL; idx_n = '0; end
      ST_TL, ST_PAY: begin
        if (payload_ready) begin
          state_n = payload_valid ? ST_PAY : ST_IFG;
          idx_n = !payload_valid ? '0 : state == ST_TL ? 11'd1 : idx + 11'd1;
          pay_done_n = payload_last || idx_n == MAX_L;
        end else if (state == ST_PAY) begin
          state_n = idx < MIN_L ? ST_PAD : ST_FCS;
          idx_n = idx < MIN_L ? idx + 11'd1 : '0;
        end
      end
      ST_PAD: begin
        state_n = idx < MIN_L ? ST_PAD : ST_FCS;
        idx_n = idx < MIN_L ? idx + 11'd1 : '0;
      end
      ST_FCS: if (idx == 11'(FCS_LEN - 1)) begin state_n = ST_IFG; idx_n = '0; end
      ST_IFG: if (idx == IFG_L) begin state_n = ST_IDLE; idx_n = '0; end
      default: begin state_n = ST_IDLE; idx_n = '0; end
    endcase
  end
  always_comb begin
    i_n = idx_n[2:0];
    fcs = state == ST_FCS ? ~crc : ~crc_next;
    control_n = !(state_n == ST_IDLE || state_n == ST_IFG);
    data_n = state_n == ST_PRE ? PREAMBLE_BYTE :
             state_n == ST_SFD ? SFD_BYTE :
             state_n == ST_DST ? 8'(dst_q >> (6'd40 - {i_n, 3'b0})) :
             state_n == ST_SRC ? 8'(src_q >> (6'd40 - {i_n, 3'b0})) :
             state_n == ST_TL  ? 8'(tl_q >> (4'd8 - {i_n[0], 3'b0})) :
             state_n == ST_PAY ? payload_data :
             state_n == ST_FCS ? 8'(fcs >> {i_n[1:0], 3'b0}) : 8'h00;
    err_n = (payload_ready && !payload_valid) || (take && idx_n == MAX_L && !payload_last);
    done_n = state == ST_FCS && idx == 11'(FCS_LEN - 2);
  end
endmodule

// File: tb/tb_epg.sv
// tb_epg: directed self-checking bench for the epg frame generator
module tb_epg;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [47:0] dst_addr = '0, src_addr = '0;
  logic [15:0] type_length = '0;
  logic [7:0] payload_data = '0;
  logic payload_valid = 1'b0, payload_last = 1'b0;
  logic payload_ready, control, busy, frame_done, tx_error;
  logic [7:0] data;
  logic [3:0] tx_packet_counter;
  logic crc_clr = 1'b0, crc_en = 1'b0;
  logic [7:0] crc_d = '0;
  logic [31:0] crc_q, crc_nx;
  int n_assert = 0, n_fail = 0;
  int cyc, pidx, plen, drop_at, done_cnt, done_cyc, err_cnt, err_cyc;
  int idle, hold, prev, gaps;
  bit pat;
  logic [7:0] rx[$];
  string msg = "123456789";

  always #5 clock = ~clock;

  epg dut (
    .clock(clock), .reset(reset), .start(start),
    .dst_addr(dst_addr), .src_addr(src_addr), .type_length(type_length),
    .payload_data(payload_data), .payload_valid(payload_valid), .payload_last(payload_last),
    .payload_ready(payload_ready), .data(data), .control(control), .busy(busy),
    .frame_done(frame_done), .tx_error(tx_error), .tx_packet_counter(tx_packet_counter)
  );

  crc32_d8 u_crc (
    .clk(clock), .rst(reset), .clr(crc_clr), .en(crc_en), .d(crc_d), .crc(crc_q), .crc_next(crc_nx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [7:0] pbyte(input int i);
    return pat ? 8'(i + 16) : 8'h55;
  endfunction

  task automatic tick();
    @(negedge clock);
    cyc++;
    if (control) rx.push_back(data);
    if (frame_done) begin done_cnt++; done_cyc = cyc; pidx = 0; end
    if (tx_error) begin err_cnt++; err_cyc = cyc; end
    if (payload_ready && pidx != drop_at) begin
      payload_valid = 1'b1;
      payload_data = pbyte(pidx);
      payload_last = (pidx == plen - 1);
      pidx++;
    end else begin
      payload_valid = 1'b0;
      payload_last = 1'b0;
      payload_data = 8'h00;
    end
  endtask

  task automatic begin_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] tl,
                             input int len, input bit p, input int drop);
    dst_addr = d; src_addr = s; type_length = tl; start = 1'b1;
    plen = len; pat = p; drop_at = drop; pidx = 0; rx.delete();
    cyc = 0; done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
  endtask

  task automatic check_frame(input int npay);
    logic [7:0] ref_q[$];
    logic [31:0] c;
    int ntot, bad;
    ntot = npay < 46 ? 46 : npay;
    for (int i = 0; i < 7; i++) ref_q.push_back(8'h55);
    ref_q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) ref_q.push_back(dst_addr[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) ref_q.push_back(src_addr[8*(5-i) +: 8]);
    ref_q.push_back(type_length[15:8]);
    ref_q.push_back(type_length[7:0]);
    for (int i = 0; i < ntot; i++) ref_q.push_back(i < npay ? pbyte(i) : 8'h00);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < ref_q.size(); i++) c = crc_upd(c, ref_q[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) ref_q.push_back(c[8*i +: 8]);
    chk("frame_len", rx.size(), ref_q.size());
    bad = ref_q.size();
    for (int i = 0; i < ref_q.size(); i++)
      if (bad == ref_q.size() && (i >= rx.size() || rx[i] !== ref_q[i])) bad = i;
    chk("first_bad_byte_index", bad, ref_q.size());
    c = 32'hFFFFFFFF;
    for (int i = 8; i < rx.size(); i++) c = crc_upd(c, rx[i]);
    chk("fcs_residue", c, 32'hDEBB20E3);
  endtask

  initial begin
    #1;
    chk("reset_data", data, 0);
    chk("reset_control", control, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", payload_ready, 0);
    chk("reset_done", frame_done, 0);
    chk("reset_err", tx_error, 0);
    chk("reset_counter", tx_packet_counter, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    crc_clr = 1'b1;
    @(negedge clock);
    crc_clr = 1'b0;
    crc_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      crc_d = msg[i];
      if (i == 8) begin #1; chk("crc_next_check", ~crc_nx, 32'hCBF43926); end
      @(negedge clock);
    end
    crc_en = 1'b0;
    chk("crc_check", ~crc_q, 32'hCBF43926);

    begin_frame(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 46, 1'b0, -1);
    idle = 0;
    for (int t = 1; t <= 85; t++) begin
      tick();
      if (t == 1) begin start = 1'b0; chk("busy_rise", busy, 1); end
      if (t == 21) chk("ready_before_payload", payload_ready, 0);
      if (t == 22) chk("ready_first", payload_ready, 1);
      if (t == 68) chk("ready_after_last", payload_ready, 0);
      if (t >= 73 && t <= 84 && !control && busy && data == 8'h00) idle++;
      if (t == 85) chk("busy_fall", busy, 0);
    end
    chk("done_cycle", done_cyc, 72);
    chk("done_count", done_cnt, 1);
    chk("counter_1", tx_packet_counter, 1);
    chk("ifg_cycles", idle, 12);
    check_frame(46);

    begin_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h000A, 10, 1'b1, -1);
    for (int t = 1; t <= 85; t++) begin
      tick();
      if (t == 1) start = 1'b0;
      if (t == 31) chk("short_ready_last", payload_ready, 1);
      if (t == 32) chk("short_ready_drop", payload_ready, 0);
    end
    chk("short_done_cycle", done_cyc, 72);
    chk("counter_2", tx_packet_counter, 2);
    check_frame(10);

    begin_frame(48'h020406080A0C, 48'h13579BDF0246, 16'h86DD, 46, 1'b1, 19);
    hold = 0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (t == 1) start = 1'b0;
      if (t == 42) begin
        chk("underrun_control", control, 0);
        chk("underrun_data", data, 0);
        chk("underrun_err", tx_error, 1);
      end
      if (t >= 42 && t <= 53 && busy) hold++;
      if (t == 54) chk("underrun_busy_fall", busy, 0);
    end
    chk("underrun_busy_hold", hold, 12);
    chk("underrun_no_done", done_cnt, 0);
    chk("underrun_err_pulses", err_cnt, 1);
    chk("underrun_counter", tx_packet_counter, 2);
    chk("underrun_bytes", rx.size(), 41);

    begin_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0600, 2000, 1'b1, -1);
    for (int t = 1; t <= 1540; t++) begin
      tick();
      if (t == 1) start = 1'b0;
      if (t == 1521) chk("oversize_ready_last", payload_ready, 1);
      if (t == 1522) begin
        chk("oversize_ready_drop", payload_ready, 0);
        chk("oversize_err", tx_error, 1);
      end
    end
    chk("oversize_err_pulses", err_cnt, 1);
    chk("oversize_done_cycle", done_cyc, 1526);
    chk("counter_3", tx_packet_counter, 3);
    check_frame(1500);

    begin_frame(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 46, 1'b0, -1);
    for (int t = 1; t <= 17; t++) begin
      tick();
      if (t == 1) start = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("midreset_control", control, 0);
    chk("midreset_data", data, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_counter", tx_packet_counter, 0);
    #1;
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_control", control, 1);
    chk("restart_data", data, 8'h55);
    reset = 1'b1;
    #1;
    reset = 1'b0;

    begin_frame(48'h0C0D0E0F1011, 48'h212223242526, 16'h0800, 46, 1'b0, -1);
    prev = -1;
    gaps = 0;
    for (int t = 1; t <= 17 * 85 + 20 && done_cnt < 17; t++) begin
      tick();
      if (frame_done) begin
        if (prev >= 0 && cyc - prev == 85) gaps++;
        prev = cyc;
      end
    end
    start = 1'b0;
    chk("b2b_done_count", done_cnt, 17);
    chk("b2b_period", gaps, 16);
    chk("b2b_counter_wrap", tx_packet_counter, 1);
    repeat (15) tick();
    chk("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
